// File: rtl/rtc_poll_ctrl.sv
// rtc_poll_ctrl: periodically reads the RTC timekeeping registers through a byte-level I2C master.
// Each poll writes register pointer 0x00, then burst-reads NUM_REGS bytes and publishes them atomically.
module rtc_poll_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         POLL_CYCLES = 50_000_000,
    parameter int         NUM_REGS    = 7,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    enable,
    input  logic                    poll_now,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [1:0]              cmd_op,
    output logic [7:0]              cmd_wdata,
    output logic                    cmd_rd_nack,
    input  logic                    rsp_valid,
    input  logic [7:0]              rsp_rdata,
    input  logic                    rsp_ack_err,
    output logic [8*NUM_REGS-1:0]   time_data,
    output logic                    time_valid,
    output logic                    busy,
    output logic                    error
);

    localparam int TIMER_W = $clog2(POLL_CYCLES);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [3:0]         LAST_READ  = 4'(4 + NUM_REGS);
    localparam logic [3:0]         STOP_STEP  = 4'(5 + NUM_REGS);

    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_STOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_ABORT,
        ST_ABORT_WAIT,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             step;
    logic [RETRY_W-1:0]     retry;
    logic [TIMER_W-1:0]     timer;
    logic                   pending;
    logic [8*NUM_REGS-1:0]  shadow;

    op_t                    step_op;
    logic [7:0]             step_wdata;
    logic                   step_nack;
    logic                   timer_wrap;
    logic                   start_req;
    logic                   retry_exhausted;

    assign timer_wrap      = enable && (state == ST_IDLE) && (timer == TIMER_LAST);
    assign start_req       = poll_now || pending || timer_wrap;
    assign retry_exhausted = (retry >= RETRY_LAST);

    // Steps 5..4+NUM_REGS are reads; the final step is the STOP.
    always_comb begin
        step_op    = OP_READ;
        step_wdata = 8'h00;
        step_nack  = 1'b0;
        case (step)
            4'd0, 4'd3: step_op = OP_START;
            4'd1: begin
                step_op    = OP_WRITE;
                step_wdata = {SLAVE_ADDR, 1'b0};
            end
            4'd2: step_op = OP_WRITE;
            4'd4: begin
                step_op    = OP_WRITE;
                step_wdata = {SLAVE_ADDR, 1'b1};
            end
            default: begin
                if (step == STOP_STEP) begin
                    step_op = OP_STOP;
                end
                step_nack = (step == LAST_READ);
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cmd_valid   = 1'b0;
        cmd_op      = OP_START;
        cmd_wdata   = 8'h00;
        cmd_rd_nack = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_valid   = 1'b1;
                cmd_op      = step_op;
                cmd_wdata   = step_wdata;
                cmd_rd_nack = step_nack;
                if (cmd_ready) begin
                    state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (step_op == OP_WRITE && rsp_ack_err) begin
                        state_next = ST_ABORT;
                    end else if (step_op == OP_STOP) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ABORT: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_STOP;
                if (cmd_ready) begin
                    state_next = ST_ABORT_WAIT;
                end
            end
            ST_ABORT_WAIT: begin
                if (rsp_valid) begin
                    state_next = retry_exhausted ? ST_FAIL : ST_ISSUE;
                end
            end
            ST_DONE, ST_FAIL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Snapshot bytes land in the shadow first so time_data only ever changes as a whole.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            step       <= 4'd0;
            retry      <= '0;
            timer      <= '0;
            pending    <= 1'b0;
            shadow     <= '0;
            time_data  <= '0;
            time_valid <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            time_valid <= 1'b0;

            if (!enable) begin
                timer <= '0;
            end else if (state == ST_IDLE) begin
                timer <= timer_wrap ? '0 : timer + TIMER_W'(1);
            end

            if (state != ST_IDLE && poll_now) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        busy    <= 1'b1;
                        retry   <= '0;
                        step    <= 4'd0;
                        pending <= 1'b0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (step_op == OP_READ) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (step == 4'(5 + i)) begin
                                    shadow[8*i +: 8] <= rsp_rdata;
                                end
                            end
                        end
                        if (!(step_op == OP_WRITE && rsp_ack_err) && step_op != OP_STOP) begin
                            step <= step + 4'd1;
                        end
                    end
                end
                ST_ABORT_WAIT: begin
                    if (rsp_valid) begin
                        retry <= retry + RETRY_W'(1);
                        step  <= 4'd0;
                    end
                end
                ST_DONE: begin
                    time_data  <= shadow;
                    time_valid <= 1'b1;
                    error      <= 1'b0;
                    busy       <= 1'b0;
                end
                ST_FAIL: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_poll_ctrl.sv
// Self-checking bench for rtc_poll_ctrl: behavioural I2C master/RTC responder plus
// an expected-command-sequence and snapshot model built from the poll rules.
module tb_rtc_poll_ctrl;

    localparam logic [6:0] SLAVE_ADDR  = 7'h68;
    localparam int         POLL_CYCLES = 100;
    localparam int         NUM_REGS    = 7;
    localparam int         MAX_RETRY   = 3;
    localparam int         DW          = 8 * NUM_REGS;
    localparam logic [7:0] ADDR_W      = {SLAVE_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R      = {SLAVE_ADDR, 1'b1};

    logic          sys_clk;
    logic          sys_rst_n;
    logic          enable;
    logic          poll_now;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_wdata;
    logic          cmd_rd_nack;
    logic          rsp_valid;
    logic [7:0]    rsp_rdata;
    logic          rsp_ack_err;
    logic [DW-1:0] time_data;
    logic          time_valid;
    logic          busy;
    logic          error;

    int compared;
    int mismatched;

    logic [7:0]  slave_regs [8];
    int          nack_mode;
    int          noise;
    int          rsp_lat_rand;
    int          stall_idx;
    int          stall_len;
    int          stall_cnt;
    int          stall_viol;
    int          tv_count;
    logic [10:0] cmd_log [$];
    logic [10:0] exp_q [$];
    logic [DW-1:0] exp_time;

    rtc_poll_ctrl #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .POLL_CYCLES(POLL_CYCLES),
        .NUM_REGS   (NUM_REGS),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .enable     (enable),
        .poll_now   (poll_now),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cmd_wdata),
        .cmd_rd_nack(cmd_rd_nack),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_ack_err(rsp_ack_err),
        .time_data  (time_data),
        .time_valid (time_valid),
        .busy       (busy),
        .error      (error)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural master + RTC: logs accepted commands, answers each after a latency.
    initial begin : responder
        int          countdown;
        int          rd_ptr;
        logic        pend_err;
        logic [7:0]  pend_data;
        logic [10:0] cur;
        logic [10:0] held;
        countdown = 0;
        rd_ptr    = 0;
        pend_err  = 1'b0;
        pend_data = 8'h00;
        held      = '0;
        forever begin
            @(negedge sys_clk);
            rsp_valid   = 1'b0;
            rsp_ack_err = 1'b0;
            rsp_rdata   = 8'h00;
            cmd_ready   = 1'b1;
            if (sys_rst_n !== 1'b1) begin
                countdown = 0;
            end else begin
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        rsp_valid   = 1'b1;
                        rsp_ack_err = pend_err;
                        rsp_rdata   = pend_data;
                    end
                end
                cur = {cmd_op, cmd_wdata, cmd_rd_nack};
                if (cmd_valid === 1'b1) begin
                    if (cmd_log.size() == stall_idx && stall_cnt < stall_len) begin
                        cmd_ready = 1'b0;
                        if (stall_cnt > 0 && cur !== held) stall_viol++;
                        held = cur;
                        stall_cnt++;
                    end else begin
                        if (cmd_log.size() == stall_idx && cur !== held) stall_viol++;
                        cmd_log.push_back(cur);
                        countdown = (rsp_lat_rand != 0) ? int'($urandom_range(1, 4)) : 3;
                        pend_err  = 1'b0;
                        pend_data = 8'($urandom);
                        if (cmd_op == 2'b01) begin
                            if (cmd_wdata == 8'h00) begin
                                rd_ptr = 0;
                            end else if (nack_mode == 2) begin
                                pend_err = 1'b1;
                            end else if (nack_mode == 1) begin
                                pend_err  = 1'b1;
                                nack_mode = 0;
                            end
                        end else begin
                            pend_err = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                            if (cmd_op == 2'b10) begin
                                pend_data = slave_regs[rd_ptr % 8];
                                rd_ptr++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (time_valid === 1'b1) tv_count++;
        end
    end

    function automatic logic [DW-1:0] snap();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = slave_regs[i];
        return v;
    endfunction

    task automatic exp_full();
        exp_q.push_back({2'b00, 8'h00, 1'b0});
        exp_q.push_back({2'b01, ADDR_W, 1'b0});
        exp_q.push_back({2'b01, 8'h00, 1'b0});
        exp_q.push_back({2'b00, 8'h00, 1'b0});
        exp_q.push_back({2'b01, ADDR_R, 1'b0});
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back({2'b10, 8'h00, i == NUM_REGS - 1});
        exp_q.push_back({2'b11, 8'h00, 1'b0});
    endtask

    task automatic exp_abort();
        exp_q.push_back({2'b00, 8'h00, 1'b0});
        exp_q.push_back({2'b01, ADDR_W, 1'b0});
        exp_q.push_back({2'b11, 8'h00, 1'b0});
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 8; i++) slave_regs[i] = 8'($urandom);
    endtask

    task automatic wait_not_busy(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge sys_clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_poll();
        @(negedge sys_clk);
        poll_now = 1'b1;
        @(negedge sys_clk);
        poll_now = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        enable    = 1'b1;
        repeat (3) @(negedge sys_clk);
        compared++; if (cmd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset cmd_valid: got %b expected 0", cmd_valid); end
        compared++; if (cmd_op !== 2'b00) begin mismatched++; $display("[TB] FAIL reset cmd_op: got %b expected 00", cmd_op); end
        compared++; if (cmd_wdata !== 8'h00) begin mismatched++; $display("[TB] FAIL reset cmd_wdata: got %h expected 00", cmd_wdata); end
        compared++; if (cmd_rd_nack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset cmd_rd_nack: got %b expected 0", cmd_rd_nack); end
        compared++; if (time_data !== '0) begin mismatched++; $display("[TB] FAIL reset time_data: got %h expected 0", time_data); end
        compared++; if (time_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset time_valid: got %b expected 0", time_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset error: got %b expected 0", error); end
    endtask

    task automatic test_timer_poll();
        int n;
        int tv0;
        bit ok;
        for (int i = 0; i < 8; i++) slave_regs[i] = 8'h11 + 8'(i);
        cmd_log.delete();
        exp_q.delete();
        exp_full();
        tv0 = tv_count;
        sys_rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            n++;
        end while (busy !== 1'b1 && n < POLL_CYCLES + 20);
        compared++; if (n != POLL_CYCLES) begin mismatched++; $display("[TB] FAIL timer_poll start cycle: got %0d expected %0d", n, POLL_CYCLES); end
        wait_not_busy(600, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL timer_poll completion: busy stuck, expected release"); end
        enable = 1'b0;
        repeat (3) @(negedge sys_clk);
        compared++; if (cmd_log.size() != exp_q.size()) begin mismatched++; $display("[TB] FAIL timer_poll cmd count: got %0d expected %0d", cmd_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            compared++; if (cmd_log[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL timer_poll cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_q[i]); end
        end
        exp_time = snap();
        compared++; if (time_data !== exp_time) begin mismatched++; $display("[TB] FAIL timer_poll time_data: got %h expected %h", time_data, exp_time); end
        compared++; if (tv_count - tv0 != 1) begin mismatched++; $display("[TB] FAIL timer_poll time_valid pulses: got %0d expected 1", tv_count - tv0); end
        compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL timer_poll error: got %b expected 0", error); end
    endtask

    task automatic test_nack_retry();
        int tv0;
        bit ok;
        randomize_regs();
        noise = 1;
        rsp_lat_rand = 1;
        nack_mode = 1;
        cmd_log.delete();
        exp_q.delete();
        exp_abort();
        exp_full();
        tv0 = tv_count;
        pulse_poll();
        wait_not_busy(800, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL nack_retry completion: busy stuck, expected release"); end
        repeat (3) @(negedge sys_clk);
        compared++; if (cmd_log.size() != exp_q.size()) begin mismatched++; $display("[TB] FAIL nack_retry cmd count: got %0d expected %0d", cmd_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            compared++; if (cmd_log[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL nack_retry cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_q[i]); end
        end
        exp_time = snap();
        compared++; if (time_data !== exp_time) begin mismatched++; $display("[TB] FAIL nack_retry time_data: got %h expected %h", time_data, exp_time); end
        compared++; if (tv_count - tv0 != 1) begin mismatched++; $display("[TB] FAIL nack_retry time_valid pulses: got %0d expected 1", tv_count - tv0); end
        compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL nack_retry error: got %b expected 0", error); end
    endtask

    task automatic test_retry_exhaust();
        int tv0;
        bit ok;
        randomize_regs();
        nack_mode = 2;
        cmd_log.delete();
        exp_q.delete();
        for (int a = 0; a < MAX_RETRY; a++) exp_abort();
        tv0 = tv_count;
        pulse_poll();
        wait_not_busy(800, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL retry_exhaust completion: busy stuck, expected release"); end
        repeat (3) @(negedge sys_clk);
        nack_mode = 0;
        compared++; if (cmd_log.size() != exp_q.size()) begin mismatched++; $display("[TB] FAIL retry_exhaust cmd count: got %0d expected %0d", cmd_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            compared++; if (cmd_log[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL retry_exhaust cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_q[i]); end
        end
        compared++; if (error !== 1'b1) begin mismatched++; $display("[TB] FAIL retry_exhaust error: got %b expected 1", error); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL retry_exhaust busy: got %b expected 0", busy); end
        compared++; if (time_data !== exp_time) begin mismatched++; $display("[TB] FAIL retry_exhaust time_data: got %h expected %h", time_data, exp_time); end
        compared++; if (tv_count != tv0) begin mismatched++; $display("[TB] FAIL retry_exhaust time_valid pulses: got %0d expected 0", tv_count - tv0); end
    endtask

    task automatic test_stall();
        int tv0;
        bit ok;
        randomize_regs();
        cmd_log.delete();
        exp_q.delete();
        exp_full();
        stall_cnt  = 0;
        stall_viol = 0;
        stall_len  = 20;
        stall_idx  = 3;
        tv0 = tv_count;
        pulse_poll();
        wait_not_busy(800, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL stall completion: busy stuck, expected release"); end
        repeat (3) @(negedge sys_clk);
        stall_idx = -1;
        compared++; if (stall_cnt != 20) begin mismatched++; $display("[TB] FAIL stall held cycles: got %0d expected 20", stall_cnt); end
        compared++; if (stall_viol != 0) begin mismatched++; $display("[TB] FAIL stall command stability: got %0d changes expected 0", stall_viol); end
        compared++; if (cmd_log.size() != exp_q.size()) begin mismatched++; $display("[TB] FAIL stall cmd count: got %0d expected %0d", cmd_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            compared++; if (cmd_log[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL stall cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_q[i]); end
        end
        exp_time = snap();
        compared++; if (time_data !== exp_time) begin mismatched++; $display("[TB] FAIL stall time_data: got %h expected %h", time_data, exp_time); end
        compared++; if (error !== 1'b0) begin mismatched++; $display("[TB] FAIL stall error cleared: got %b expected 0", error); end
        compared++; if (tv_count - tv0 != 1) begin mismatched++; $display("[TB] FAIL stall time_valid pulses: got %0d expected 1", tv_count - tv0); end
    endtask

    task automatic test_back_to_back();
        int tv0;
        int extra;
        bit ok;
        randomize_regs();
        cmd_log.delete();
        exp_q.delete();
        exp_full();
        exp_full();
        tv0 = tv_count;
        pulse_poll();
        repeat (6) @(negedge sys_clk);
        pulse_poll();
        repeat (4) @(negedge sys_clk);
        pulse_poll();
        wait_not_busy(800, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL back_to_back first completion: busy stuck, expected release"); end
        compared++; if (time_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL back_to_back time_valid at busy drop: got %b expected 1", time_valid); end
        @(negedge sys_clk);
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL back_to_back pending start: busy got %b expected 1", busy); end
        wait_not_busy(800, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL back_to_back second completion: busy stuck, expected release"); end
        extra = 0;
        repeat (40) begin
            @(negedge sys_clk);
            if (busy === 1'b1) extra++;
        end
        compared++; if (extra != 0) begin mismatched++; $display("[TB] FAIL back_to_back extra polls: busy high %0d cycles expected 0", extra); end
        compared++; if (cmd_log.size() != exp_q.size()) begin mismatched++; $display("[TB] FAIL back_to_back cmd count: got %0d expected %0d", cmd_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            compared++; if (cmd_log[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL back_to_back cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_q[i]); end
        end
        compared++; if (tv_count - tv0 != 2) begin mismatched++; $display("[TB] FAIL back_to_back time_valid pulses: got %0d expected 2", tv_count - tv0); end
        exp_time = snap();
        compared++; if (time_data !== exp_time) begin mismatched++; $display("[TB] FAIL back_to_back time_data: got %h expected %h", time_data, exp_time); end
    endtask

    task automatic test_reset_mid();
        int n;
        int tv0;
        bit ok;
        randomize_regs();
        rsp_lat_rand = 0;
        enable = 1'b1;
        cmd_log.delete();
        pulse_poll();
        n = 0;
        while (cmd_log.size() < 8 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        compared++; if (cmd_log.size() < 8) begin mismatched++; $display("[TB] FAIL reset_mid third read: got %0d commands expected 8", cmd_log.size()); end
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        compared++; if (cmd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mid cmd_valid: got %b expected 0", cmd_valid); end
        compared++; if (cmd_op !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_mid cmd_op: got %b expected 00", cmd_op); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mid busy: got %b expected 0", busy); end
        compared++; if (time_data !== '0) begin mismatched++; $display("[TB] FAIL reset_mid time_data: got %h expected 0", time_data); end
        compared++; if (time_valid !== 1'b0 || error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mid flags: got valid=%b error=%b expected 0/0", time_valid, error); end
        randomize_regs();
        cmd_log.delete();
        exp_q.delete();
        exp_full();
        tv0 = tv_count;
        sys_rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            n++;
        end while (busy !== 1'b1 && n < POLL_CYCLES + 20);
        compared++; if (n != POLL_CYCLES) begin mismatched++; $display("[TB] FAIL reset_mid restart cycle: got %0d expected %0d", n, POLL_CYCLES); end
        wait_not_busy(600, ok);
        enable = 1'b0;
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL reset_mid completion: busy stuck, expected release"); end
        repeat (3) @(negedge sys_clk);
        compared++; if (cmd_log.size() != exp_q.size()) begin mismatched++; $display("[TB] FAIL reset_mid cmd count: got %0d expected %0d", cmd_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            compared++; if (cmd_log[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL reset_mid cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_q[i]); end
        end
        exp_time = snap();
        compared++; if (time_data !== exp_time) begin mismatched++; $display("[TB] FAIL reset_mid time_data: got %h expected %h", time_data, exp_time); end
        compared++; if (tv_count - tv0 != 1) begin mismatched++; $display("[TB] FAIL reset_mid time_valid pulses: got %0d expected 1", tv_count - tv0); end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        sys_rst_n    = 1'b0;
        enable       = 1'b0;
        poll_now     = 1'b0;
        cmd_ready    = 1'b1;
        rsp_valid    = 1'b0;
        rsp_rdata    = 8'h00;
        rsp_ack_err  = 1'b0;
        nack_mode    = 0;
        noise        = 0;
        rsp_lat_rand = 0;
        stall_idx    = -1;
        stall_len    = 0;
        stall_cnt    = 0;
        stall_viol   = 0;
        tv_count     = 0;
        exp_time     = '0;
        for (int i = 0; i < 8; i++) slave_regs[i] = 8'h00;

        $display("[TB] rtc_poll_ctrl bench start");
        test_reset();
        test_timer_poll();
        test_nack_retry();
        test_retry_exhaust();
        test_stall();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
